// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display driver and its scan decoder.
// Segment constants are active-low gfedcba so encoder and decoder agree bit for bit.
package display_pkg;

  localparam int unsigned DIGITS   = 8;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned IDX_W    = $clog2(DIGITS);
  localparam int unsigned DATA_W   = DIGITS * NIBBLE_W;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_SAMPLED  = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    AN_BLANK  = 2'd0,
    AN_ACTIVE = 2'd1,
    AN_MULTI  = 2'd2
  } anode_class_e;

  typedef struct packed {
    logic                valid;
    logic [NIBBLE_W-1:0] nibble;
  } hex_digit_t;

  // Encoder side of the shared table.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
    case (nibble)
      4'h0: hex_to_seg = SEG_0;
      4'h1: hex_to_seg = SEG_1;
      4'h2: hex_to_seg = SEG_2;
      4'h3: hex_to_seg = SEG_3;
      4'h4: hex_to_seg = SEG_4;
      4'h5: hex_to_seg = SEG_5;
      4'h6: hex_to_seg = SEG_6;
      4'h7: hex_to_seg = SEG_7;
      4'h8: hex_to_seg = SEG_8;
      4'h9: hex_to_seg = SEG_9;
      4'hA: hex_to_seg = SEG_A;
      4'hB: hex_to_seg = SEG_B;
      4'hC: hex_to_seg = SEG_C;
      4'hD: hex_to_seg = SEG_D;
      4'hE: hex_to_seg = SEG_E;
      default: hex_to_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Combinational active-low segment pattern to {valid, nibble}; unknown patterns flag invalid.
module seg_to_hex
  import display_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output hex_digit_t       hex_c
);

  always_comb begin
    hex_c.valid  = 1'b1;
    hex_c.nibble = 4'h0;
    case (seg)
      SEG_0: hex_c.nibble = 4'h0;
      SEG_1: hex_c.nibble = 4'h1;
      SEG_2: hex_c.nibble = 4'h2;
      SEG_3: hex_c.nibble = 4'h3;
      SEG_4: hex_c.nibble = 4'h4;
      SEG_5: hex_c.nibble = 4'h5;
      SEG_6: hex_c.nibble = 4'h6;
      SEG_7: hex_c.nibble = 4'h7;
      SEG_8: hex_c.nibble = 4'h8;
      SEG_9: hex_c.nibble = 4'h9;
      SEG_A: hex_c.nibble = 4'hA;
      SEG_B: hex_c.nibble = 4'hB;
      SEG_C: hex_c.nibble = 4'hC;
      SEG_D: hex_c.nibble = 4'hD;
      SEG_E: hex_c.nibble = 4'hE;
      SEG_F: hex_c.nibble = 4'hF;
      default: hex_c.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_scan_decoder.sv
// Samples a multiplexed anode/cathode display bus, decodes each settled digit and
// reassembles the 32-bit value shown once all eight digits have been seen.
module display_scan_decoder
  import display_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIGITS-1:0] anode,
  input  logic [7:0]        cathode,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_done,
  output logic              decode_error
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);

  logic [DIGITS-1:0] anode_q, anode_p;
  logic [7:0]        cathode_q, cathode_p;
  scan_state_e       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
  anode_class_e      an_class_c;
  logic [IDX_W-1:0]  idx_c;
  logic [3:0]        zeros_c;
  logic              changed_c, sample_c;
  hex_digit_t        dec_c;
  logic [DIGITS-1:0] idx_mask_c;
  logic [DIGITS-1:0][NIBBLE_W-1:0] shadow, shadow_merged_c;
  logic [DIGITS-1:0] seen;

  // Input stage plus a one-cycle-older copy for change detection; blank after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      anode_q   <= '1;
      cathode_q <= '1;
      anode_p   <= '1;
      cathode_p <= '1;
    end else begin
      anode_q   <= anode;
      cathode_q <= cathode;
      anode_p   <= anode_q;
      cathode_p <= cathode_q;
    end
  end

  always_comb begin
    zeros_c = 4'd0;
    idx_c   = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!anode_q[i]) begin
        zeros_c = zeros_c + 4'd1;
        idx_c   = IDX_W'(i);
      end
    end
    if (zeros_c == 4'd0)      an_class_c = AN_BLANK;
    else if (zeros_c == 4'd1) an_class_c = AN_ACTIVE;
    else                      an_class_c = AN_MULTI;
  end

  assign changed_c = (anode_q != anode_p) || (cathode_q != cathode_p);
  assign cnt_inc   = cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Dwell tracking: one sample per stable dwell, counter saturates at the limit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sample_c   = 1'b0;
    if (an_class_c != AN_ACTIVE) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_SETTLING;
          cnt_next   = '0;
        end
        ST_SETTLING: begin
          if (changed_c) begin
            cnt_next = '0;
          end else if (cnt_inc >= SETTLE_LIM) begin
            sample_c   = 1'b1;
            state_next = ST_SAMPLED;
            cnt_next   = SETTLE_LIM;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_SAMPLED: begin
          if (changed_c) begin
            state_next = ST_SETTLING;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  seg_to_hex u_seg_to_hex (
    .seg   (cathode_q[SEG_W-1:0]),
    .hex_c (dec_c)
  );

  always_comb begin
    idx_mask_c             = DIGITS'(1) << idx_c;
    shadow_merged_c        = shadow;
    shadow_merged_c[idx_c] = dec_c.nibble;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow       <= '0;
      seen         <= '0;
      data         <= '0;
      valid        <= 1'b0;
      frame_done   <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sample_c) begin
        if (dec_c.valid) begin
          shadow <= shadow_merged_c;
          if ((seen | idx_mask_c) == '1) begin
            data       <= shadow_merged_c;
            valid      <= 1'b1;
            frame_done <= 1'b1;
            seen       <= '0;
          end else begin
            seen <= seen | idx_mask_c;
          end
        end else begin
          decode_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan_decoder.sv
// Randomized and directed bench for display_scan_decoder against a pin-history reference model.
module tb_display_scan_decoder;

  localparam int unsigned S = 4;

  logic        clock;
  logic        reset;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic [31:0] data;
  logic        valid;
  logic        frame_done;
  logic        decode_error;

  display_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clock        (clock),
    .reset        (reset),
    .anode        (anode),
    .cathode      (cathode),
    .data         (data),
    .valid        (valid),
    .frame_done   (frame_done),
    .decode_error (decode_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: what the outputs must be after each edge.
  logic [3:0]  m_shadow [8];
  logic [7:0]  m_seen;
  logic [31:0] m_data;
  logic        m_valid, m_fd, m_err;
  int          run;
  logic        have_prev;
  logic [7:0]  prev_an, prev_ca;
  logic        pend;
  int          pend_idx;
  logic [6:0]  pend_seg;

  int checks = 0;
  int passed = 0;
  int fd_count = 0;

  function automatic int lookup(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (seg_tab[k] == s) return k;
    return -1;
  endfunction

  // A pin value held unchanged for S+1 cycles with one anode low is sampled;
  // its effect is applied one edge later and visible the cycle after that.
  task automatic model_edge(input logic [7:0] an, input logic [7:0] ca, input logic rst);
    int n;
    m_fd = 1'b0;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_shadow[i] = 4'h0;
      m_seen = 8'h00; m_data = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      pend = 1'b0; run = 0; have_prev = 1'b0;
      return;
    end
    if (pend) begin
      n = lookup(pend_seg);
      if (n < 0) m_err = 1'b1;
      else begin
        m_shadow[pend_idx] = 4'(n);
        m_seen[pend_idx] = 1'b1;
        if (m_seen == 8'hFF) begin
          for (int i = 0; i < 8; i++) m_data[4*i +: 4] = m_shadow[i];
          m_valid = 1'b1;
          m_fd = 1'b1;
          m_seen = 8'h00;
        end
      end
      pend = 1'b0;
    end
    if (have_prev && an == prev_an && ca == prev_ca) run++;
    else run = 1;
    have_prev = 1'b1;
    prev_an = an;
    prev_ca = ca;
    if (run == int'(S) + 1 && $countones(~an) == 1) begin
      pend = 1'b1;
      for (int i = 0; i < 8; i++) if (!an[i]) pend_idx = i;
      pend_seg = ca[6:0];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input logic [7:0] an, input logic [7:0] ca, input logic rst);
    anode = an;
    cathode = ca;
    reset = rst;
    @(posedge clock);
    model_edge(an, ca, rst);
    @(negedge clock);
    check("data", data, m_data);
    check("flags", {29'b0, valid, frame_done, decode_error}, {29'b0, m_valid, m_fd, m_err});
    if (frame_done === 1'b1) fd_count++;
  endtask

  task automatic show(input int idx, input logic [3:0] nib, input int hold, input logic dp);
    logic [7:0] an;
    an = ~(8'd1 << idx);
    repeat (hold) tick(an, {dp, seg_tab[nib]}, 1'b0);
  endtask

  task automatic blank(input int n);
    repeat (n) tick(8'hFF, 8'hFF, 1'b0);
  endtask

  initial begin
    logic [31:0] word;
    logic [3:0]  r;
    logic [7:0]  an, ca;
    int          hold, kind;

    reset = 1'b1; anode = 8'hFF; cathode = 8'hFF;
    repeat (3) tick(8'hFF, 8'hFF, 1'b1);
    check("reset_data", data, 32'h0);
    check("reset_flags", {29'b0, valid, frame_done, decode_error}, 32'h0);
    blank(3);

    // Loopback of a driver showing 12345678.
    fd_count = 0;
    word = 32'h12345678;
    for (int d = 0; d < 8; d++) show(d, word[4*d +: 4], int'(S) + 2, 1'b1);
    blank(4);
    check("loop_data", data, 32'h12345678);
    check("loop_valid", {31'b0, valid}, 32'd1);
    check("loop_err", {31'b0, decode_error}, 32'd0);
    check("loop_fd_count", fd_count, 32'd1);

    // Per-digit sweep F..8 with dp differing between digits.
    fd_count = 0;
    for (int d = 0; d < 8; d++) show(d, 4'(15 - d), int'(S) + 2, d[0]);
    blank(4);
    check("sweep_data", data, 32'h89ABCDEF);
    check("sweep_fd_count", fd_count, 32'd1);

    // Short glitch on digit 3 must not be sampled.
    fd_count = 0;
    word = 32'h0;
    word[15:12] = 4'h7;
    show(3, 4'h5, 2, 1'b1);
    show(3, 4'h7, 6, 1'b1);
    for (int d = 0; d < 8; d++) begin
      if (d != 3) begin
        r = 4'($urandom);
        word[4*d +: 4] = r;
        show(d, r, int'(S) + 2, 1'b1);
      end
    end
    blank(4);
    check("glitch_nibble3", {28'b0, data[15:12]}, 32'h7);
    check("glitch_data", data, word);
    check("glitch_fd_count", fd_count, 32'd1);

    // Multi-hot then blank: nothing sampled.
    fd_count = 0;
    repeat (20) tick(8'b11110011, {1'b1, seg_tab[2]}, 1'b0);
    repeat (20) tick(8'hFF, {1'b1, seg_tab[2]}, 1'b0);
    check("multi_fd_count", fd_count, 32'd0);
    check("multi_data", data, word);
    check("multi_state_idle", {30'b0, dut.state}, 32'd0);

    // Invalid pattern on digit 2 after a valid C on the same digit.
    fd_count = 0;
    show(2, 4'hC, int'(S) + 2, 1'b1);
    repeat (int'(S) + 2) tick(8'b11111011, 8'hFF, 1'b0);
    blank(2);
    check("invalid_err", {31'b0, decode_error}, 32'd1);
    for (int d = 0; d < 8; d++) if (d != 2) show(d, 4'($urandom), int'(S) + 2, 1'b1);
    blank(4);
    check("invalid_nibble2", {28'b0, data[11:8]}, 32'hC);
    check("invalid_fd_count", fd_count, 32'd1);
    for (int d = 0; d < 8; d++) show(d, 4'($urandom), int'(S) + 2, 1'b1);
    blank(4);
    check("invalid_err_sticky", {31'b0, decode_error}, 32'd1);

    // Reset mid-frame discards the partial frame.
    for (int d = 0; d < 5; d++) show(d, 4'h3, int'(S) + 2, 1'b1);
    tick(8'b11011111, {1'b1, seg_tab[3]}, 1'b1);
    check("midreset_valid", {31'b0, valid}, 32'd0);
    check("midreset_err", {31'b0, decode_error}, 32'd0);
    fd_count = 0;
    for (int d = 0; d < 8; d++) begin
      show(d, 4'hF, int'(S) + 2, 1'b1);
      if (d < 7) check("midreset_no_early_fd", fd_count, 32'd0);
    end
    blank(4);
    check("midreset_data", data, 32'hFFFFFFFF);
    check("midreset_fd_count", fd_count, 32'd1);

    // Random dwells, classes, patterns and occasional resets.
    repeat (400) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) an = 8'hFF;
      else if (kind == 1) begin
        an = 8'($urandom);
        if ($countones(~an) == 1) an = 8'h0F;
      end else an = ~(8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ca = 8'($urandom);
      else ca = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
      hold = int'($urandom_range(1, S + 3));
      repeat (hold) tick(an, ca, 1'b0);
      if ($urandom_range(0, 59) == 0) tick(an, ca, 1'b1);
    end
    blank(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_decoder.md
# display_scan_decoder

Receive-side counterpart of the `Display` seven-segment driver. It samples a multiplexed 8-digit anode/cathode bus, decodes each digit's segment pattern back to a hex nibble, and reassembles the 32-bit value the driver is showing. It is used in board loopback self-test and in benches that check `Display` output end to end.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive cycles anode and cathode must hold unchanged before a digit is sampled; legal range 1–255.
- `clock` in 1: single system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `anode` in 8: active-low one-hot digit select. `anode[i]` low selects digit i; digit 0 is the rightmost and least significant.
- `cathode` in 8: active-low segments. `cathode[7]` = dp (ignored); `cathode[6:0]` = g,f,e,d,c,b,a.
- `data` out 32: last complete frame; digit i maps to `data[4i+3:4i]`.
- `valid` out 1: high once at least one complete frame has been latched.
- `frame_done` out 1: one-cycle pulse when `data` updates.
- `decode_error` out 1: sticky; set by an unrecognised segment pattern; cleared only by `reset`.

## Operation
- **Input stage:** `anode` and `cathode` are registered once (`anode_q`, `cathode_q`). All decoding uses the registered copies.
- **Anode classification:**
  - exactly one bit low: ACTIVE, with digit index idx;
  - all bits high: BLANK;
  - anything else: MULTI.
- **FSM states:** IDLE, SETTLING, SAMPLED.
  - IDLE: entered from any state when the class is BLANK or MULTI; the stable counter is held at 0. Goes to SETTLING when the class becomes ACTIVE.
  - SETTLING: the stable counter increments each cycle that `anode_q` and `cathode_q` equal their previous values. Any change resets the counter to 0 and stays in SETTLING (or goes to IDLE if the new class is not ACTIVE). When the counter reaches `SETTLE_CYCLES`, perform a sample and go to SAMPLED.
  - SAMPLED: no further samples for this dwell. Any change in `anode_q` or `cathode_q` goes to SETTLING (class ACTIVE) or IDLE.
- **Sample action:**
  - Decode `cathode_q[6:0]` to a nibble.
  - Valid pattern: write the nibble to `shadow[idx]` and set `seen[idx]`.
  - Invalid pattern: set `decode_error`; leave `shadow` and `seen` untouched.
- **Active-low patterns, hex gfedcba:** 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- **Frame completion:** when `seen` becomes 8'hFF (including the current write):
  - `data` is loaded with `shadow` plus the new nibble;
  - `valid` is set to 1 and `frame_done` pulses;
  - `seen` clears in the same cycle.
- **Repeated digit:** re-sampling a digit before the frame completes overwrites that nibble; it does not complete the frame early.
- **Reset:** all outputs 0, `seen` 0, `shadow` 0, FSM to IDLE, stable counter 0. A reset mid-frame discards the partial frame.

## Timing
- Input register latency: 1 cycle.
- Sample occurs `SETTLE_CYCLES` cycles after `anode_q`/`cathode_q` last changed, i.e. `SETTLE_CYCLES`+1 cycles after a pin change.
- `data`, `valid`, `frame_done` and `decode_error` are registered. They are visible the cycle after the sample cycle.
- A dwell shorter than `SETTLE_CYCLES` stable cycles is never sampled.
- An anode change and a cathode change in the same cycle count as one change.
- `frame_done` is never high on two consecutive cycles. The minimum spacing between pulses is 8×(`SETTLE_CYCLES`+1) cycles.
- The stable counter saturates at `SETTLE_CYCLES`; it never wraps.

## Structure
- Shared package `display_pkg`:
  - `DIGITS` = 8;
  - the 16 segment-pattern constants, also used by the `Display` encoder so both ends agree;
  - FSM state encoding.
- One sub-module, `seg_to_hex`: combinational 7-bit pattern to {valid, nibble}.
- Top level holds:
  - input registers;
  - anode classifier / one-hot-to-index;
  - FSM and stable counter;
  - `shadow`/`seen` and output registers.

## Test plan
- **Loopback:** `Display` driven with 32'h12345678, its `cathode`/`anode` connected here. Required: first `frame_done` gives `data`=32'h12345678, `valid`=1, `decode_error`=0.
- **Per-digit stimulus:** sweep digits 0–7 with patterns F,E,D,C,B,A,9,8, each held `SETTLE_CYCLES`+2 cycles. Required: `data`=32'h89ABCDEF, exactly one `frame_done`, and `dp` toggling has no effect.
- **Glitch rejection:** with `SETTLE_CYCLES`=4, hold digit 3 = 5 for 2 cycles, then = 7 for 6 cycles, then complete the frame. Required: nibble 3 = 7.
- **Multi-hot / blank:** `anode`=8'b11110011 for 20 cycles, then 8'hFF for 20 cycles. Required: no sample, `seen` unchanged, FSM in IDLE.
- **Invalid pattern:** digit 2 with `cathode[6:0]`=7'h7F (blank). Required: `decode_error`=1 the cycle after the sample; it stays 1 after later valid frames; `data` nibble 2 keeps its prior value.
- **Reset mid-frame:** 5 digits sampled, `reset` for 1 cycle, then a full frame of 32'hFFFFFFFF. Required: `valid`=0 after reset; a single `frame_done` only after all 8 new digits; `data`=32'hFFFFFFFF.
